// File: rtl/ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of ram_stream_reader.
// The slave modport is the reader itself; the master modport is its environment
// (command source, RAM read port and stream consumer).
interface ram_stream_reader_if #(
  parameter int DW = 8,
  parameter int AW = 10
);

  logic          start;
  logic          abort;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;

  logic          ram_rd;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_dat;

  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;
  logic          out_last;

  modport master (
    output start, abort, base, len, ram_dat, out_rdy,
    input  busy, done, ram_rd, ram_adr, out_vld, out_dat, out_last
  );

  modport slave (
    input  start, abort, base, len, ram_dat, out_rdy,
    output busy, done, ram_rd, ram_adr, out_vld, out_dat, out_last
  );

endinterface

// File: rtl/ram_stream_reader.sv
// RAM stream reader: issues len consecutive RAM reads from base (address
// wrapping modulo MD) and presents the returned words as a valid/ready stream
// with a last flag. A credit check (in-flight reads + FIFO occupancy < FD)
// guarantees every returning word has a FIFO slot, so backpressure never
// drops data even though the RAM itself cannot be stalled.
module ram_stream_reader #(
  parameter int DW = 8,
  parameter int MD = 1024,
  parameter int AW = $clog2(MD),
  parameter int RL = 2,
  parameter int FD = 4
) (
  input logic             clk,
  input logic             rst,
  ram_stream_reader_if.slave bus
);

  localparam int CW = $clog2(FD + 1);
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic [AW:0]   remaining;
  logic [AW-1:0] adr;

  // In-flight read tracking: one valid bit and one last tag per RAM latency stage.
  logic [RL-1:0] pipe_vld;
  logic [RL-1:0] pipe_last;
  logic [CW-1:0] inflight;

  // Output FIFO.
  logic [DW-1:0] fifo_dat [FD];
  logic [FD-1:0] fifo_last;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          issue;
  logic          last_issue;
  logic          ret;
  logic          pop;
  logic [AW-1:0] adr_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Read issue, return and pop decisions, all derived from registered state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    issue      = 1'b0;
    last_issue = 1'b0;
    adr_next   = (adr == AW'(MD - 1)) ? '0 : adr + AW'(1);
    if (state == READ && remaining != '0 &&
        ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(FD)) begin
      issue      = 1'b1;
      last_issue = (remaining == (AW + 1)'(1));
    end
    ret = pipe_vld[RL-1];
    pop = (count != '0) && bus.out_rdy;
  end

  // Control FSM: command acceptance, address/length counters, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      remaining <= '0;
      adr       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      if (bus.abort) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        remaining <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.len != '0) begin
                state     <= READ;
                busy_q    <= 1'b1;
                remaining <= bus.len;
                adr       <= bus.base;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          READ: begin
            if (issue) begin
              adr       <= adr_next;
              remaining <= remaining - (AW + 1)'(1);
              if (last_issue) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (pop && fifo_last[rd_ptr]) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Latency shift register, credit counters and FIFO pointers; abort flushes all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      inflight  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (bus.abort) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      inflight  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= last_issue;
      for (int i = 1; i < RL; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      // A pop frees its slot only from the next cycle on, since count is registered.
      inflight <= inflight + CW'(issue) - CW'(ret);
      count    <= count + CW'(ret) - CW'(pop);
      if (ret) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage: returning words are written at the tail with their last tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset so the stream data outputs read 0 out of reset; a RAM-macro FIFO would drop this.
      for (int i = 0; i < FD; i++) begin
        fifo_dat[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else if (ret) begin
      fifo_dat[wr_ptr]  <= bus.ram_dat;
      fifo_last[wr_ptr] <= pipe_last[RL-1];
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ram_rd   = issue;
  assign bus.ram_adr  = adr;
  assign bus.out_vld  = (count != '0);
  assign bus.out_dat  = fifo_dat[rd_ptr];
  assign bus.out_last = fifo_last[rd_ptr];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: a registered-read RAM model (RL=2), a
// table of directed transfers, hand-written reset/backpressure/busy-start/abort
// sequences and randomized transfers checked against a queue-level model
// (word k of a transfer is mem[(base+k) % MD], last only on word len-1).
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_stream_reader_if #(.DW(DW), .AW(AW)) bus ();

  ram_stream_reader #(.DW(DW), .MD(MD), .AW(AW), .RL(RL), .FD(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Registered-read RAM with clock enable tied high: data appears two cycles after the address.
  logic [DW-1:0] mem [MD];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[bus.ram_adr];
    rd2 <= rd1;
  end
  assign bus.ram_dat = rd2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observations of the most recent transfer.
  logic [DW:0]   got_q [$];
  logic [AW-1:0] adr_q [$];
  int first_vld, done_cyc, done_cnt, busy_first, busy_last, rd_stall;

  // Start a transfer in the current cycle (cycle 0) and run it to completion.
  // Outputs are sampled at the falling edge; inputs for that cycle are set right after.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] l, input int rdy_pct,
                          input int stall, input int restart_at, input int abort_words);
    logic          hold;
    logic [DW+1:0] held;
    int            abort_cyc;
    int            budget;
    bit            rdy;
    bit            finished;
    got_q.delete();
    adr_q.delete();
    first_vld = -1; done_cyc = -1; done_cnt = 0;
    busy_first = -1; busy_last = -1; rd_stall = 0;
    abort_cyc = -1; hold = 1'b0; held = '0; finished = 1'b0;
    budget = 10 * int'(l) + stall + 40;
    bus.start = 1'b1; bus.abort = 1'b0; bus.base = b; bus.len = l; bus.out_rdy = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      bus.abort = 1'b0;
      if (bus.ram_rd) begin
        adr_q.push_back(bus.ram_adr);
        if (c <= stall) rd_stall++;
      end
      if (bus.busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (bus.out_vld && first_vld < 0) first_vld = c;
      if (hold) check("hold_stable", {bus.out_vld, bus.out_last, bus.out_dat}, held);
      if (abort_cyc >= 0 && c == abort_cyc + 1) begin
        check("abort_out_vld", bus.out_vld, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
      end
      if (abort_words >= 0 && abort_cyc < 0 && got_q.size() == abort_words) begin
        bus.abort = 1'b1;
        abort_cyc = c;
      end
      rdy = (c > stall) && (c != abort_cyc) && ($urandom_range(99) < rdy_pct);
      bus.out_rdy = rdy;
      if (bus.out_vld && rdy) got_q.push_back({bus.out_last, bus.out_dat});
      hold = bus.out_vld && !rdy && !bus.abort;
      held = {bus.out_vld, bus.out_last, bus.out_dat};
      if ((done_cyc >= 0 && c >= done_cyc + 2) || (abort_cyc >= 0 && c >= abort_cyc + 6)) begin
        finished = 1'b1;
        break;
      end
    end
    bus.out_rdy = 1'b0;
    check("xfer_terminated", finished, 1);
  endtask

  // Compare the observed stream and read addresses with the reference sequence.
  task automatic check_stream(input string tag, input logic [AW-1:0] b, input logic [AW:0] l);
    int a;
    check({tag, " words"}, got_q.size(), l);
    check({tag, " reads"}, adr_q.size(), l);
    check({tag, " done_count"}, done_cnt, 1);
    for (int k = 0; k < got_q.size() && k < int'(l); k++) begin
      a = (int'(b) + k) % MD;
      check({tag, " word"}, got_q[k], {(k == int'(l) - 1), mem[a]});
    end
    for (int k = 0; k < adr_q.size() && k < int'(l); k++) begin
      a = (int'(b) + k) % MD;
      check({tag, " ram_adr"}, adr_q[k], a);
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < MD; i++) mem[i] = DW'(i);
  endtask

  typedef struct {
    int base;
    int len;
    int first_vld;
    int done_cyc;
    int busy_first;
    int busy_last;
  } vec_t;

  vec_t vecs [6];
  int   n_rd, n_vld, n_busy;

  initial begin
    // Directed transfers with out_rdy held high: {base, len, first out_vld, done, busy first, busy last}.
    vecs[0] = '{3,  5,  4,  9,  1,  8};
    vecs[1] = '{14, 4,  4,  8,  1,  7};
    vecs[2] = '{0,  0, -1,  1, -1, -1};
    vecs[3] = '{10, 20, 4,  24, 1,  23};
    vecs[4] = '{15, 1,  4,  5,  1,  4};
    vecs[5] = '{0,  16, 4,  20, 1,  19};

    bus.start = 1'b0; bus.abort = 1'b0; bus.base = '0; bus.len = '0; bus.out_rdy = 1'b0;
    fill_identity();

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst ram_rd", bus.ram_rd, 0);
    check("rst out_vld", bus.out_vld, 0);
    check("rst out_dat", {bus.out_last, bus.out_dat}, 0);
    rst = 1'b0;

    // Reset asserted mid-transfer: outputs clear at once, nothing is read afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.base = 4'd5; bus.len = 5'd8; bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst out_vld", bus.out_vld, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst ram_rd", bus.ram_rd, 0);
    check("midrst ram_adr", bus.ram_adr, 0);
    check("midrst out_vld", bus.out_vld, 0);
    check("midrst out_dat", {bus.out_last, bus.out_dat}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_rd = 0; n_vld = 0; n_busy = 0;
    repeat (6) begin
      @(negedge clk);
      n_rd += int'(bus.ram_rd);
      n_vld += int'(bus.out_vld);
      n_busy += int'(bus.busy);
    end
    check("post_rst ram_rd count", n_rd, 0);
    check("post_rst out_vld count", n_vld, 0);
    check("post_rst busy count", n_busy, 0);
    bus.out_rdy = 1'b0;

    // Table-driven directed transfers.
    foreach (vecs[i]) begin
      run_xfer(AW'(vecs[i].base), (AW + 1)'(vecs[i].len), 100, 0, -1, -1);
      check("vec first_vld", first_vld, vecs[i].first_vld);
      check("vec done_cyc", done_cyc, vecs[i].done_cyc);
      check("vec busy_first", busy_first, vecs[i].busy_first);
      check("vec busy_last", busy_last, vecs[i].busy_last);
      check_stream("vec", AW'(vecs[i].base), (AW + 1)'(vecs[i].len));
    end

    // Backpressure: consumer stalls for 12 cycles.
    run_xfer(4'd0, 5'd10, 100, 12, -1, -1);
    check("bp ram_rd limited", rd_stall <= 4, 1);
    check("bp first_vld", first_vld, 4);
    check_stream("bp", 4'd0, 5'd10);

    // Start pulse while busy is ignored.
    run_xfer(4'd2, 5'd8, 100, 0, 3, -1);
    check("busy_start done_cyc", done_cyc, 12);
    check_stream("busy_start", 4'd2, 5'd8);

    // Abort after two words, then a fresh transfer.
    run_xfer(4'd0, 5'd8, 100, 0, -1, 2);
    check("abort words", got_q.size(), 2);
    check("abort done_count", done_cnt, 0);
    check("abort word0", got_q[0], 9'd0);
    check("abort word1", got_q[1], 9'd1);
    run_xfer(4'd5, 5'd2, 100, 0, -1, -1);
    check_stream("after_abort", 4'd5, 5'd2);

    // Randomized transfers against the queue model.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < MD; i++) mem[i] = DW'($urandom);
      run_xfer(AW'($urandom_range(MD - 1)), (AW + 1)'($urandom_range(0, 31)),
               int'($urandom_range(30, 100)), 0, -1, -1);
      check_stream("rand", bus.base, bus.len);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
